jump_ctrl: RTL and testbench

Control-flow resolver that drives the program counter's `absjump_en`/`target` inputs from decoded jump operations. It holds a writable jump-target lookup table and a return-address stack for call/return. Stack misuse enters a sticky fault state that forces execution to a trap vector. It sits between the instruction decoder and the program counter in the single-cycle datapath.

---
 rtl/jump_ctrl_pkg.sv | 17 +
 rtl/ret_stack.sv | 50 +++++
 rtl/jump_ctrl.sv | 144 ++++++++++++++
 tb/tb_jump_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/jump_ctrl_pkg.sv
// Shared types for the jump controller: decoded jump operations and controller states.
package jump_ctrl_pkg;

    typedef enum logic [2:0] {
        NONE   = 3'd0,
        JUMP   = 3'd1,
        BRANCH = 3'd2,
        CALL   = 3'd3,
        RET    = 3'd4
    } op_t;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO with occupancy count, synchronous clear and async active-low reset.
module ret_stack #(
    parameter int unsigned D     = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clr,
    input  logic [D-1:0]               din,
    output logic [D-1:0]               top,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PtrOne  = 1;
    localparam logic [AW:0]   CntOne  = 1;
    localparam logic [AW:0]   FullCnt = (AW+1)'(DEPTH);

    logic [D-1:0]  mem_q [DEPTH];
    logic [AW:0]   cnt_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] top_ptr;

    assign wr_ptr  = cnt_q[AW-1:0];
    assign top_ptr = wr_ptr - PtrOne;
    assign full    = (cnt_q == FullCnt);
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign top     = empty ? '0 : mem_q[top_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr) begin
            cnt_q <= '0;
        end else if (push && !full) begin
            mem_q[wr_ptr] <= din;
            cnt_q         <= cnt_q + CntOne;
        end else if (pop && !empty) begin
            cnt_q <= cnt_q - CntOne;
        end
    end

endmodule

// File: rtl/jump_ctrl.sv
// Resolves decoded jump ops into PC absjump_en/target using a writable target LUT,
// a return-address stack, and a sticky FAULT state that redirects to the trap vector.
module jump_ctrl
    import jump_ctrl_pkg::*;
#(
    parameter int unsigned     D     = 12,
    parameter int unsigned     LUT_N = 16,
    parameter int unsigned     DEPTH = 4,
    parameter logic [D-1:0]    TRAP  = 12'hFF0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [D-1:0]               prog_ctr,
    input  logic [2:0]                 op,
    input  logic                       cond,
    input  logic [$clog2(LUT_N)-1:0]   lut_idx,
    input  logic                       lut_we,
    input  logic [$clog2(LUT_N)-1:0]   lut_waddr,
    input  logic [D-1:0]               lut_wdata,
    input  logic                       clear_fault,
    output logic                       absjump_en,
    output logic [D-1:0]               target,
    output logic [$clog2(DEPTH):0]     sp,
    output logic                       fault,
    output logic                       overflow,
    output logic                       underflow
);
    localparam logic [D-1:0] PcOne = 1;

    logic [D-1:0] lut_q [LUT_N];
    logic [D-1:0] lut_rd;
    state_t       state_q;
    logic         ovf_q, udf_q;

    logic         push, pop, clr;
    logic         full, empty;
    logic [D-1:0] stack_top;
    logic         jump_en;
    logic [D-1:0] jump_tgt;

    assign lut_rd = lut_q[lut_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < LUT_N; i++) begin
                lut_q[i] <= '0;
            end
        end else if (lut_we) begin
            lut_q[lut_waddr] <= lut_wdata;
        end
    end

    always_comb begin
        push     = 1'b0;
        pop      = 1'b0;
        clr      = 1'b0;
        jump_en  = 1'b0;
        jump_tgt = '0;
        if (state_q == FAULT) begin
            jump_en  = 1'b1;
            jump_tgt = TRAP;
            clr      = clear_fault;
        end else begin
            // Undefined op codes fall through to the NONE behaviour.
            case (op)
                JUMP: begin
                    jump_en  = 1'b1;
                    jump_tgt = lut_rd;
                end
                BRANCH: begin
                    jump_en  = cond;
                    jump_tgt = cond ? lut_rd : '0;
                end
                CALL: begin
                    if (!full) begin
                        push     = 1'b1;
                        jump_en  = 1'b1;
                        jump_tgt = lut_rd;
                    end
                end
                RET: begin
                    if (!empty) begin
                        pop      = 1'b1;
                        jump_en  = 1'b1;
                        jump_tgt = stack_top;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (op == CALL && full) begin
                        state_q <= FAULT;
                        ovf_q   <= 1'b1;
                    end else if (op == RET && empty) begin
                        state_q <= FAULT;
                        udf_q   <= 1'b1;
                    end
                end
                FAULT: begin
                    if (clear_fault) begin
                        state_q <= RUN;
                        ovf_q   <= 1'b0;
                        udf_q   <= 1'b0;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    ret_stack #(
        .D     (D),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clr   (clr),
        .din   (prog_ctr + PcOne),
        .top   (stack_top),
        .count (sp),
        .full  (full),
        .empty (empty)
    );

    // Jump outputs are forced quiet while reset is held, independent of the clock.
    assign absjump_en = reset & jump_en;
    assign target     = reset ? jump_tgt : '0;
    assign fault      = (state_q == FAULT);
    assign overflow   = ovf_q;
    assign underflow  = udf_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// Directed, table-driven bench for jump_ctrl plus hand sequences for fault and reset cases.
module tb_jump_ctrl;
    import jump_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] prog_ctr;
    logic [2:0]  op;
    logic        cond;
    logic [3:0]  lut_idx;
    logic        lut_we;
    logic [3:0]  lut_waddr;
    logic [11:0] lut_wdata;
    logic        clear_fault;
    logic        absjump_en;
    logic [11:0] target;
    logic [2:0]  sp;
    logic        fault;
    logic        overflow;
    logic        underflow;

    int n_checks = 0;
    int n_fail   = 0;

    jump_ctrl #(
        .D     (12),
        .LUT_N (16),
        .DEPTH (4),
        .TRAP  (12'hFF0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .prog_ctr    (prog_ctr),
        .op          (op),
        .cond        (cond),
        .lut_idx     (lut_idx),
        .lut_we      (lut_we),
        .lut_waddr   (lut_waddr),
        .lut_wdata   (lut_wdata),
        .clear_fault (clear_fault),
        .absjump_en  (absjump_en),
        .target      (target),
        .sp          (sp),
        .fault       (fault),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1);
    end

    typedef struct {
        logic [2:0]  op;
        logic        cond;
        logic [3:0]  idx;
        logic        we;
        logic [3:0]  waddr;
        logic [11:0] wdata;
        logic [11:0] pc;
        logic        clr;
        logic        en;
        logic [11:0] tgt;
        logic [2:0]  sp;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic [2:0] o, input logic c, input logic [3:0] idx,
                       input logic [11:0] pc, input logic clr,
                       input logic we, input logic [3:0] wa, input logic [11:0] wd);
        @(posedge clk);
        #1;
        op = o; cond = c; lut_idx = idx; prog_ctr = pc; clear_fault = clr;
        lut_we = we; lut_waddr = wa; lut_wdata = wd;
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{JUMP,   1'b0, 4'd3, 1'b1, 4'd3, 12'h040, 12'h000, 1'b0, 1'b1, 12'h000, 3'd0};
        vecs[1]  = '{JUMP,   1'b0, 4'd3, 1'b0, 4'd0, 12'h000, 12'h000, 1'b0, 1'b1, 12'h040, 3'd0};
        vecs[2]  = '{BRANCH, 1'b0, 4'd3, 1'b0, 4'd0, 12'h000, 12'h000, 1'b0, 1'b0, 12'h000, 3'd0};
        vecs[3]  = '{BRANCH, 1'b1, 4'd3, 1'b0, 4'd0, 12'h000, 12'h000, 1'b0, 1'b1, 12'h040, 3'd0};
        vecs[4]  = '{NONE,   1'b0, 4'd3, 1'b1, 4'd5, 12'h200, 12'h000, 1'b0, 1'b0, 12'h000, 3'd0};
        vecs[5]  = '{CALL,   1'b0, 4'd5, 1'b0, 4'd0, 12'h000, 12'h010, 1'b0, 1'b1, 12'h200, 3'd0};
        vecs[6]  = '{NONE,   1'b0, 4'd5, 1'b0, 4'd0, 12'h000, 12'h011, 1'b0, 1'b0, 12'h000, 3'd1};
        vecs[7]  = '{RET,    1'b0, 4'd5, 1'b0, 4'd0, 12'h000, 12'h012, 1'b0, 1'b1, 12'h011, 3'd1};
        vecs[8]  = '{NONE,   1'b0, 4'd5, 1'b0, 4'd0, 12'h000, 12'h011, 1'b0, 1'b0, 12'h000, 3'd0};
        vecs[9]  = '{CALL,   1'b0, 4'd5, 1'b0, 4'd0, 12'h000, 12'hFFF, 1'b0, 1'b1, 12'h200, 3'd0};
        vecs[10] = '{RET,    1'b0, 4'd5, 1'b0, 4'd0, 12'h000, 12'h200, 1'b0, 1'b1, 12'h000, 3'd1};
        vecs[11] = '{3'd5,   1'b1, 4'd3, 1'b0, 4'd0, 12'h000, 12'h000, 1'b0, 1'b0, 12'h000, 3'd0};
        vecs[12] = '{3'd7,   1'b1, 4'd3, 1'b0, 4'd0, 12'h000, 12'h000, 1'b0, 1'b0, 12'h000, 3'd0};
        vecs[13] = '{NONE,   1'b0, 4'd3, 1'b0, 4'd0, 12'h000, 12'h000, 1'b1, 1'b0, 12'h000, 3'd0};

        // Reset held low with a JUMP presented: outputs must stay quiet.
        reset = 1'b0; prog_ctr = '0; op = JUMP; cond = 1'b0; lut_idx = 4'd3;
        lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0; clear_fault = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_en", {31'b0, absjump_en}, 32'd0);
        check("reset_tgt", {20'b0, target}, 32'd0);
        check("reset_sp", {29'b0, sp}, 32'd0);
        check("reset_fault", {31'b0, fault}, 32'd0);
        check("reset_ovf", {31'b0, overflow}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            cyc(vecs[i].op, vecs[i].cond, vecs[i].idx, vecs[i].pc, vecs[i].clr,
                vecs[i].we, vecs[i].waddr, vecs[i].wdata);
            check($sformatf("vec%0d_en", i), {31'b0, absjump_en}, {31'b0, vecs[i].en});
            check($sformatf("vec%0d_tgt", i), {20'b0, target}, {20'b0, vecs[i].tgt});
            check($sformatf("vec%0d_sp", i), {29'b0, sp}, {29'b0, vecs[i].sp});
            check($sformatf("vec%0d_fault", i), {31'b0, fault}, 32'd0);
        end

        // Overflow: four CALLs fill the stack, the fifth faults.
        for (int k = 0; k < 4; k++) begin
            cyc(CALL, 1'b0, 4'd5, 12'h100 + 12'(k), 1'b0, 1'b0, 4'd0, 12'h000);
            check($sformatf("call%0d_en", k), {31'b0, absjump_en}, 32'd1);
            check($sformatf("call%0d_tgt", k), {20'b0, target}, 32'h200);
            check($sformatf("call%0d_sp", k), {29'b0, sp}, k);
        end
        cyc(CALL, 1'b0, 4'd5, 12'h104, 1'b0, 1'b0, 4'd0, 12'h000);
        check("ovf_call_en", {31'b0, absjump_en}, 32'd0);
        check("ovf_call_sp", {29'b0, sp}, 32'd4);
        check("ovf_call_fault", {31'b0, fault}, 32'd0);
        cyc(RET, 1'b0, 4'd5, 12'h105, 1'b0, 1'b0, 4'd0, 12'h000);
        check("ovf_fault", {31'b0, fault}, 32'd1);
        check("ovf_flag", {31'b0, overflow}, 32'd1);
        check("ovf_trap_en", {31'b0, absjump_en}, 32'd1);
        check("ovf_trap_tgt", {20'b0, target}, 32'hFF0);
        check("ovf_ret_ignored_sp", {29'b0, sp}, 32'd4);
        cyc(CALL, 1'b0, 4'd5, 12'h106, 1'b0, 1'b1, 4'd6, 12'h0AB);
        check("ovf_hold_sp", {29'b0, sp}, 32'd4);
        check("ovf_hold_tgt", {20'b0, target}, 32'hFF0);
        cyc(NONE, 1'b0, 4'd0, 12'h107, 1'b1, 1'b0, 4'd0, 12'h000);
        check("ovf_clr_cycle_fault", {31'b0, fault}, 32'd1);
        check("ovf_clr_cycle_tgt", {20'b0, target}, 32'hFF0);
        cyc(JUMP, 1'b0, 4'd6, 12'h108, 1'b0, 1'b0, 4'd0, 12'h000);
        check("ovf_cleared_fault", {31'b0, fault}, 32'd0);
        check("ovf_cleared_flag", {31'b0, overflow}, 32'd0);
        check("ovf_cleared_sp", {29'b0, sp}, 32'd0);
        check("lut_write_in_fault", {20'b0, target}, 32'h0AB);

        // Underflow: RET on empty stack, then a CALL issued while faulted.
        cyc(RET, 1'b0, 4'd5, 12'h020, 1'b0, 1'b0, 4'd0, 12'h000);
        check("udf_ret_en", {31'b0, absjump_en}, 32'd0);
        check("udf_ret_fault", {31'b0, fault}, 32'd0);
        cyc(CALL, 1'b0, 4'd5, 12'h021, 1'b0, 1'b0, 4'd0, 12'h000);
        check("udf_fault", {31'b0, fault}, 32'd1);
        check("udf_flag", {31'b0, underflow}, 32'd1);
        check("udf_ovf_clear", {31'b0, overflow}, 32'd0);
        check("udf_trap_tgt", {20'b0, target}, 32'hFF0);
        cyc(NONE, 1'b0, 4'd0, 12'h022, 1'b1, 1'b0, 4'd0, 12'h000);
        check("udf_call_ignored_sp", {29'b0, sp}, 32'd0);
        check("udf_still_fault", {31'b0, fault}, 32'd1);
        cyc(NONE, 1'b0, 4'd0, 12'h023, 1'b0, 1'b0, 4'd0, 12'h000);
        check("udf_cleared_fault", {31'b0, fault}, 32'd0);
        check("udf_cleared_flag", {31'b0, underflow}, 32'd0);
        check("udf_cleared_en", {31'b0, absjump_en}, 32'd0);

        // Asynchronous reset between edges with two entries on the stack.
        cyc(CALL, 1'b0, 4'd5, 12'h030, 1'b0, 1'b0, 4'd0, 12'h000);
        cyc(CALL, 1'b0, 4'd5, 12'h031, 1'b0, 1'b0, 4'd0, 12'h000);
        cyc(JUMP, 1'b0, 4'd3, 12'h032, 1'b0, 1'b0, 4'd0, 12'h000);
        check("pre_rst_sp", {29'b0, sp}, 32'd2);
        check("pre_rst_tgt", {20'b0, target}, 32'h040);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_sp", {29'b0, sp}, 32'd0);
        check("async_rst_en", {31'b0, absjump_en}, 32'd0);
        check("async_rst_tgt", {20'b0, target}, 32'd0);
        check("async_rst_fault", {31'b0, fault}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst_en", {31'b0, absjump_en}, 32'd1);
        check("post_rst_lut_zero", {20'b0, target}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
